ecc_apb_ctrl: RTL and testbench
===============================

ECC_APB_CTRL -- requirements
Module: ecc_apb_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, max codeword width (8/16/32).
REQ-002 SHALL have parameter AMBA_WORD, default 32, APB data width.
REQ-003 SHALL have parameter AMBA_ADDR_WIDTH, default 20, APB address width.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have APB ports PADDR in AMBA_ADDR_WIDTH, PSEL in 1, PENABLE in 1, PWRITE in 1, PWDATA in AMBA_WORD, PRDATA out AMBA_WORD; zero-wait, no PREADY.
REQ-007 SHALL have port enc_info  out  DATA_WIDTH  snapshot of DATA_IN driven to Encoder.info.
REQ-008 SHALL have port enc_cw_width  out  AMBA_WORD  snapshot of CODEWORD_WIDTH driven to Encoder.CODEWORD_WIDTH.
REQ-009 SHALL have port enc_codeword  in  DATA_WIDTH  combinational result returned by Encoder.
REQ-010 SHALL have port chan_out  out  DATA_WIDTH  word for downstream decoder; chan_valid  out  1  one-cycle qualifier.
REQ-011 SHALL have port data_out  out  DATA_WIDTH  result; operation_done  out  1  one-cycle completion pulse.

Function
REQ-012 SHALL decode registers by PADDR[4:0]: 0x00 CTRL[1:0], 0x04 DATA_IN, 0x08 CODEWORD_WIDTH[1:0], 0x0C NOISE, 0x10 DATA_OUT (RO), 0x14 STATUS (bit0 busy, RO).
REQ-013 SHALL write a register on the edge where PSEL&PENABLE&PWRITE; writes to RO/unmapped addresses ignored.
REQ-014 SHALL return PRDATA combinationally when PSEL&!PWRITE; unmapped addresses read 0.
REQ-015 SHALL use FSM IDLE->LOAD->DONE->IDLE; a CTRL write in IDLE with mode 0 (encode), 1 (decode) or 2 (full) enters LOAD; mode 3 ignored, no launch.
REQ-016 SHALL snapshot DATA_IN, CODEWORD_WIDTH, NOISE and mode on the launching edge; later register writes do not affect the running operation.
REQ-017 SHALL stay in LOAD one cycle driving snapshots on enc_info/enc_cw_width; at end of LOAD register result.
REQ-018 SHALL compute active width W = 8/16/32 for CODEWORD_WIDTH 0/1/>=2, clipped to DATA_WIDTH; NOISE and result bits >= W forced to 0.
REQ-019 SHALL register result: mode 0 data_out=enc_codeword; mode 2 chan_out=enc_codeword^noise, data_out=same; mode 1 chan_out=DATA_IN^noise, data_out=same.
REQ-020 SHALL assert operation_done in DONE for exactly one cycle (second cycle after launch edge); chan_valid same cycle for modes 1/2 only.
REQ-021 SHALL report busy=1 in LOAD and DONE; CTRL writes while busy ignored.
REQ-022 SHALL hold data_out/chan_out until next completed operation.
REQ-023 SHALL, on CTRL write in DONE cycle, ignore it (busy); software re-issues.

Reset
REQ-024 SHALL on rst=0 immediately force state IDLE, all registers, enc_info, enc_cw_width, chan_out, data_out, PRDATA-source regs to 0, operation_done=0, chan_valid=0.
REQ-025 SHALL abort any in-flight operation on reset with no done pulse after release.

Structure
REQ-026 SHALL place register offsets, mode encodings, width codes and FSM state enum in shared package ecc_pkg.
REQ-027 SHALL implement the APB register file as sub-module ecc_apb_regs; FSM and snapshot/result logic at top.
REQ-028 SHALL keep the Encoder external; connection by the parent.

Verification
REQ-029 SHALL test: DATA_IN=0x1, CW_WIDTH=0, CTRL=0 -> operation_done 2 cycles later, data_out=0x1B.
REQ-030 SHALL test: same with NOISE=0x01, CTRL=2 -> chan_out=0x1A, chan_valid=1 one cycle, data_out=0x1A.
REQ-031 SHALL test: CW_WIDTH=0, NOISE=0xFFFF0001, CTRL=1, DATA_IN=0x1B -> chan_out=0x1A (upper bits masked).
REQ-032 SHALL test: CTRL write during LOAD and CTRL=3 in IDLE -> no extra done pulse, STATUS busy reads 1 then 0.
REQ-033 SHALL test: DATA_IN rewritten to 0x5 in LOAD -> result still from 0x1 (0x1B).
REQ-034 SHALL test: rst low during LOAD -> outputs 0 immediately, no operation_done after release, readback of all regs 0.

Source files
------------

// File: rtl/ecc_pkg.sv
// ============================================================================
// Module      : ecc_pkg
// Description : Shared register map, mode/width encodings and FSM states for
//               the ECC APB controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ecc_pkg;

    localparam logic [4:0] c_ADDR_CTRL     = 5'h00;
    localparam logic [4:0] c_ADDR_DATA_IN  = 5'h04;
    localparam logic [4:0] c_ADDR_CW_WIDTH = 5'h08;
    localparam logic [4:0] c_ADDR_NOISE    = 5'h0C;
    localparam logic [4:0] c_ADDR_DATA_OUT = 5'h10;
    localparam logic [4:0] c_ADDR_STATUS   = 5'h14;

    localparam logic [1:0] c_MODE_ENC  = 2'd0;
    localparam logic [1:0] c_MODE_DEC  = 2'd1;
    localparam logic [1:0] c_MODE_FULL = 2'd2;
    localparam logic [1:0] c_MODE_RSVD = 2'd3;

    localparam logic [1:0] c_CW_8  = 2'd0;
    localparam logic [1:0] c_CW_16 = 2'd1;
    localparam logic [1:0] c_CW_32 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Active-width mask; any code above 16-bit selects 32, then clipped to dw.
    function automatic logic [31:0] width_mask(input logic [1:0] code, input int unsigned dw);
        int unsigned w;
        if (code == c_CW_8)
            w = 8;
        else if (code == c_CW_16)
            w = 16;
        else
            w = 32;
        if (w > dw)
            w = dw;
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ecc_apb_regs.sv
// ============================================================================
// Module      : ecc_apb_regs
// Description : Zero-wait APB register file for the ECC controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ecc_apb_regs
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [AMBA_WORD-1:0]       PWDATA,
    output logic [AMBA_WORD-1:0]       PRDATA,
    input  logic                       i_busy,
    input  logic [DATA_WIDTH-1:0]      i_data_out,
    output logic                       o_ctrl_wr,
    output logic [1:0]                 o_ctrl_mode,
    output logic [DATA_WIDTH-1:0]      o_data_in,
    output logic [1:0]                 o_cw_width,
    output logic [DATA_WIDTH-1:0]      o_noise
);

    logic [4:0]            w_addr;
    logic                  w_wr;
    logic                  w_unused;
    logic [1:0]            r_ctrl;
    logic [DATA_WIDTH-1:0] r_data_in;
    logic [1:0]            r_cw_width;
    logic [DATA_WIDTH-1:0] r_noise;

    assign w_addr   = PADDR[4:0];
    assign w_wr     = PSEL & PENABLE & PWRITE;
    assign w_unused = ^{PADDR, PWDATA};

    assign o_ctrl_wr   = w_wr && (w_addr == c_ADDR_CTRL);
    assign o_ctrl_mode = PWDATA[1:0];
    assign o_data_in   = r_data_in;
    assign o_cw_width  = r_cw_width;
    assign o_noise     = r_noise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctrl     <= '0;
            r_data_in  <= '0;
            r_cw_width <= '0;
            r_noise    <= '0;
        end else if (w_wr) begin
            case (w_addr)
                c_ADDR_CTRL:     r_ctrl     <= PWDATA[1:0];
                c_ADDR_DATA_IN:  r_data_in  <= PWDATA[DATA_WIDTH-1:0];
                c_ADDR_CW_WIDTH: r_cw_width <= PWDATA[1:0];
                c_ADDR_NOISE:    r_noise    <= PWDATA[DATA_WIDTH-1:0];
                default:         ;
            endcase
        end
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (w_addr)
                c_ADDR_CTRL:     PRDATA[1:0]            = r_ctrl;
                c_ADDR_DATA_IN:  PRDATA[DATA_WIDTH-1:0] = r_data_in;
                c_ADDR_CW_WIDTH: PRDATA[1:0]            = r_cw_width;
                c_ADDR_NOISE:    PRDATA[DATA_WIDTH-1:0] = r_noise;
                c_ADDR_DATA_OUT: PRDATA[DATA_WIDTH-1:0] = i_data_out;
                c_ADDR_STATUS:   PRDATA[0]              = i_busy;
                default:         ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ecc_apb_ctrl.sv
// ============================================================================
// Module      : ecc_apb_ctrl
// Description : APB-controlled sequencer that drives an external encoder and
//               produces encode / decode-channel / full-path results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ecc_apb_ctrl
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [AMBA_WORD-1:0]       PWDATA,
    output logic [AMBA_WORD-1:0]       PRDATA,
    output logic [DATA_WIDTH-1:0]      enc_info,
    output logic [AMBA_WORD-1:0]       enc_cw_width,
    input  logic [DATA_WIDTH-1:0]      enc_codeword,
    output logic [DATA_WIDTH-1:0]      chan_out,
    output logic                       chan_valid,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       operation_done
);

    logic                  w_ctrl_wr;
    logic [1:0]            w_ctrl_mode;
    logic [DATA_WIDTH-1:0] w_data_in;
    logic [1:0]            w_cw_width;
    logic [DATA_WIDTH-1:0] w_noise;
    logic [31:0]           w_mask32;
    logic [DATA_WIDTH-1:0] w_mask_cur;
    logic [DATA_WIDTH-1:0] w_full_res;
    logic [DATA_WIDTH-1:0] w_dec_res;
    logic                  w_unused_mask;

    state_t                r_state;
    logic [1:0]            r_mode;
    logic [DATA_WIDTH-1:0] r_info;
    logic [1:0]            r_cw;
    logic [DATA_WIDTH-1:0] r_noise;
    logic [DATA_WIDTH-1:0] r_mask;
    logic [DATA_WIDTH-1:0] r_chan_out;
    logic                  r_chan_valid;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_op_done;

    ecc_apb_regs #(
        .DATA_WIDTH      (DATA_WIDTH),
        .AMBA_WORD       (AMBA_WORD),
        .AMBA_ADDR_WIDTH (AMBA_ADDR_WIDTH)
    ) u_regs (
        .clk         (clk),
        .rst         (rst),
        .PADDR       (PADDR),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .i_busy      (r_state != ST_IDLE),
        .i_data_out  (r_data_out),
        .o_ctrl_wr   (w_ctrl_wr),
        .o_ctrl_mode (w_ctrl_mode),
        .o_data_in   (w_data_in),
        .o_cw_width  (w_cw_width),
        .o_noise     (w_noise)
    );

    assign w_mask32      = width_mask(w_cw_width, DATA_WIDTH);
    assign w_mask_cur    = w_mask32[DATA_WIDTH-1:0];
    assign w_unused_mask = ^w_mask32;
    assign w_full_res    = (enc_codeword ^ r_noise) & r_mask;
    assign w_dec_res     = (r_info ^ r_noise) & r_mask;

    assign enc_info       = r_info;
    assign enc_cw_width   = {{(AMBA_WORD-2){1'b0}}, r_cw};
    assign chan_out       = r_chan_out;
    assign chan_valid     = r_chan_valid;
    assign data_out       = r_data_out;
    assign operation_done = r_op_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_mode       <= c_MODE_ENC;
            r_info       <= '0;
            r_cw         <= '0;
            r_noise      <= '0;
            r_mask       <= '0;
            r_chan_out   <= '0;
            r_chan_valid <= 1'b0;
            r_data_out   <= '0;
            r_op_done    <= 1'b0;
        end else begin
            r_op_done    <= 1'b0;
            r_chan_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Snapshot everything at launch so later writes cannot disturb the run.
                    if (w_ctrl_wr && (w_ctrl_mode != c_MODE_RSVD)) begin
                        r_state <= ST_LOAD;
                        r_mode  <= w_ctrl_mode;
                        r_info  <= w_data_in;
                        r_cw    <= w_cw_width;
                        r_noise <= w_noise & w_mask_cur;
                        r_mask  <= w_mask_cur;
                    end
                end
                ST_LOAD: begin
                    r_state   <= ST_DONE;
                    r_op_done <= 1'b1;
                    case (r_mode)
                        c_MODE_ENC: r_data_out <= enc_codeword & r_mask;
                        c_MODE_FULL: begin
                            r_chan_out   <= w_full_res;
                            r_data_out   <= w_full_res;
                            r_chan_valid <= 1'b1;
                        end
                        default: begin
                            r_chan_out   <= w_dec_res;
                            r_data_out   <= w_dec_res;
                            r_chan_valid <= 1'b1;
                        end
                    endcase
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ecc_apb_ctrl.sv
// ============================================================================
// Module      : tb_ecc_apb_ctrl
// Description : Directed scoreboard bench for ecc_apb_ctrl with a stand-in
//               combinational encoder (codeword = info * 27).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ecc_apb_ctrl;

    localparam logic [19:0] A_CTRL   = 20'h00;
    localparam logic [19:0] A_DIN    = 20'h04;
    localparam logic [19:0] A_CW     = 20'h08;
    localparam logic [19:0] A_NOISE  = 20'h0C;
    localparam logic [19:0] A_DOUT   = 20'h10;
    localparam logic [19:0] A_STATUS = 20'h14;
    localparam logic [19:0] A_UNMAP  = 20'h18;

    typedef struct {
        logic [31:0] dout;
        logic [31:0] cout;
        logic        cv;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] PADDR;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PWDATA, PRDATA;
    logic [31:0] enc_info, enc_cw_width, enc_codeword;
    logic [31:0] chan_out, data_out;
    logic        chan_valid, operation_done;

    int   n_pass   = 0;
    int   n_total  = 0;
    int   n_done   = 0;
    int   n_launch = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign enc_codeword = enc_info * 32'd27;

    ecc_apb_ctrl #(
        .DATA_WIDTH      (32),
        .AMBA_WORD       (32),
        .AMBA_ADDR_WIDTH (20)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .PADDR          (PADDR),
        .PSEL           (PSEL),
        .PENABLE        (PENABLE),
        .PWRITE         (PWRITE),
        .PWDATA         (PWDATA),
        .PRDATA         (PRDATA),
        .enc_info       (enc_info),
        .enc_cw_width   (enc_cw_width),
        .enc_codeword   (enc_codeword),
        .chan_out       (chan_out),
        .chan_valid     (chan_valid),
        .data_out       (data_out),
        .operation_done (operation_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Tasks start just after a rising edge and return just after one.
    task automatic apb_write(input logic [19:0] a, input logic [31:0] d);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
        @(negedge clk);
        PENABLE = 1'b1;
        @(posedge clk);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [19:0] a, output logic [31:0] d);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
        #1;
        d = PRDATA;
        PSEL = 1'b0;
    endtask

    task automatic push(input logic [31:0] dout, input logic [31:0] cout, input logic cv);
        exp_t e;
        e.dout = dout; e.cout = cout; e.cv = cv;
        sb.push_back(e);
        n_launch++;
    endtask

    task automatic launch(input logic [1:0] mode, input logic [31:0] info, input logic [31:0] cw,
                          input logic [31:0] dout, input logic [31:0] cout, input logic cv);
        push(dout, cout, cv);
        apb_write(A_CTRL, {30'd0, mode});
        check("enc_info_load", enc_info, info);
        check("enc_cw_load", enc_cw_width, cw);
        check("done_early", 32'(operation_done), 32'd0);
        @(posedge clk); #1;
        check("done_pulse", 32'(operation_done), 32'd1);
        @(posedge clk); #1;
        check("done_width", 32'(operation_done), 32'd0);
    endtask

    always @(negedge clk) begin
        if (operation_done) begin
            n_done++;
            n_total++;
            assert (sb.size() > 0) n_pass++;
            else $error("FAIL unexpected_done observed=1 expected=0");
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("data_out", data_out, e.dout);
                check("chan_out", chan_out, e.cout);
                check("chan_valid", 32'(chan_valid), 32'(e.cv));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [19:0] addrs [6];
        addrs = '{A_CTRL, A_DIN, A_CW, A_NOISE, A_DOUT, A_STATUS};

        rst = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data_out", data_out, 32'h0);
        check("rst_chan_out", chan_out, 32'h0);
        check("rst_done", 32'(operation_done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Encode, 8-bit
        apb_write(A_DIN, 32'h1);
        apb_write(A_CW, 32'h0);
        launch(2'd0, 32'h1, 32'h0, 32'h1B, 32'h0, 1'b0);

        // Full path with noise
        apb_write(A_NOISE, 32'h1);
        launch(2'd2, 32'h1, 32'h0, 32'h1A, 32'h1A, 1'b1);

        // Decode path, noise upper bits masked
        apb_write(A_NOISE, 32'hFFFF_0001);
        apb_write(A_DIN, 32'h1B);
        launch(2'd1, 32'h1B, 32'h0, 32'h1A, 32'h1A, 1'b1);
        apb_read(A_NOISE, rd);
        check("noise_readback", rd, 32'hFFFF_0001);

        // Encode, 16-bit: 0x1234*27 = 0x1EB7C, masked to 0xEB7C
        apb_write(A_CW, 32'h1);
        apb_write(A_DIN, 32'h1234);
        launch(2'd0, 32'h1234, 32'h1, 32'hEB7C, 32'h1A, 1'b0);

        // Full path, 32-bit
        apb_write(A_CW, 32'h2);
        apb_write(A_DIN, 32'h0100_0000);
        apb_write(A_NOISE, 32'h8000_0000);
        launch(2'd2, 32'h0100_0000, 32'h2, 32'h9B00_0000, 32'h9B00_0000, 1'b1);

        // CTRL writes while busy and reserved mode are ignored
        apb_write(A_CW, 32'h0);
        apb_write(A_DIN, 32'h1);
        apb_write(A_NOISE, 32'h0);
        push(32'h1B, 32'h9B00_0000, 1'b0);
        apb_write(A_CTRL, 32'h0);
        apb_read(A_STATUS, rd);
        check("busy_load", rd, 32'h1);
        apb_write(A_CTRL, 32'h1);
        check("done_after_busy_wr", 32'(operation_done), 32'd1);
        apb_read(A_STATUS, rd);
        check("busy_done", rd, 32'h1);
        apb_write(A_CTRL, 32'h2);
        apb_read(A_STATUS, rd);
        check("idle_after_done", rd, 32'h0);
        apb_write(A_CTRL, 32'h3);
        apb_read(A_STATUS, rd);
        check("mode3_no_launch", rd, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("done_count_busy", 32'(n_done), 32'(n_launch));

        // DATA_IN rewrite during LOAD does not affect result
        push(32'h1B, 32'h9B00_0000, 1'b0);
        apb_write(A_CTRL, 32'h0);
        apb_write(A_DIN, 32'h5);
        check("done_with_rewrite", 32'(operation_done), 32'd1);
        @(posedge clk); #1;
        apb_read(A_DOUT, rd);
        check("dout_readback", rd, 32'h1B);
        apb_read(A_DIN, rd);
        check("din_readback", rd, 32'h5);
        apb_read(A_UNMAP, rd);
        check("unmapped_read", rd, 32'h0);
        apb_write(A_DOUT, 32'hDEAD);
        apb_read(A_DOUT, rd);
        check("ro_write_ignored", rd, 32'h1B);

        // Reset during LOAD aborts
        apb_write(A_DIN, 32'h1);
        apb_write(A_NOISE, 32'h1);
        apb_write(A_CTRL, 32'h2);
        rst = 1'b0;
        #1;
        check("abort_data_out", data_out, 32'h0);
        check("abort_chan_out", chan_out, 32'h0);
        check("abort_enc_info", enc_info, 32'h0);
        check("abort_chan_valid", 32'(chan_valid), 32'd0);
        check("abort_done", 32'(operation_done), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            apb_read(addrs[i], rd);
            check($sformatf("post_rst_reg_%0h", addrs[i]), rd, 32'h0);
        end
        check("done_count_final", 32'(n_done), 32'(n_launch));
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
